seg7_scan_capture: RTL and testbench

- Reader for the multiplexed 7-segment display bus: observes segment lines plus digit-select lines and turns each displayed digit back into its hex nibble.
- Per-digit registers hold the recovered value, with valid flags and event pulses.
- Sits beside the display driver, or on a loop-back header, for self-test and for readback by a host or scoreboard.
- Inverse of the hex-to-segment encoding: bit0=a … bit6=g. Table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, B=1111100, C=0111001, D=1011110, E=1111001, F=1110001.

---
 rtl/seg7_scan_capture_pkg.sv | 25 ++
 rtl/seg7_to_hex.sv | 22 ++
 rtl/seg7_scan_capture.sv | 124 ++++++++++++
 tb/tb_seg7_scan_capture.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_capture_pkg.sv
// Shared constants for the 7-segment capture block: segment bit positions, the hex pattern table
// and the capture FSM state type.
package seg7_scan_capture_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry i is the segment pattern the display encoder emits for nibble i (bit0=a .. bit6=g).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational 7-segment pattern to {hit, nibble}, exact inverse of the encoder.
// Latency: zero cycles; no backpressure (pure function of seg).
module seg7_to_hex
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: recovers per-digit hex nibbles from a multiplexed 7-seg bus (SEG7_CAPTURE_ACTIVE_LOW_EN inverts inputs).
// Latency: commit lands STABLE_CYCLES+1 edges after the first sample; no backpressure, the bus is observed passively.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     valid_out,
  output logic                  upd_pulse,
  output logic                  err_pulse,
  output logic [2:0]            upd_idx
);

  logic [6:0]        in_seg;
  logic [DIGITS-1:0] in_sel;

`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
  assign in_seg = ~seg_in;
  assign in_sel = ~dig_sel;
`else
  assign in_seg = seg_in;
  assign in_sel = dig_sel;
`endif

  logic [6:0]        s_seg, p_seg;
  logic [DIGITS-1:0] s_sel, p_sel;
  cap_state_t        state, nxt_state;
  logic [CNT_W-1:0]  cnt, nxt_cnt, cnt_inc;
  logic              changed, sel_onehot, commit;
  logic [2:0]        sel_idx;
  logic              dec_hit;
  logic [3:0]        dec_nib;

  seg7_to_hex u_dec (
    .seg    (s_seg),
    .hit    (dec_hit),
    .nibble (dec_nib)
  );

  assign changed    = ({s_seg, s_sel} != {p_seg, p_sel});
  assign sel_onehot = $onehot(s_sel);
  assign cnt_inc    = cnt + 1'b1;

  always_comb begin
    sel_idx = 3'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (s_sel[k]) sel_idx = 3'(k);
    end
  end

  // The commit fires on the edge at which the counter reaches STABLE_CYCLES, so the
  // recovered value appears one edge after the last of the STABLE_CYCLES identical samples.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    commit    = 1'b0;
    if (changed) begin
      nxt_state = sel_onehot ? TRACK : IDLE;
      nxt_cnt   = sel_onehot ? CNT_W'(1) : '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_cnt = '0;
        end
        TRACK: begin
          nxt_cnt = cnt_inc;
          if (cnt_inc == CNT_W'(STABLE_CYCLES)) begin
            commit    = 1'b1;
            nxt_state = HELD;
          end
        end
        HELD: begin
          nxt_cnt = cnt;
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_seg      <= '0;
      s_sel      <= '0;
      p_seg      <= '0;
      p_sel      <= '0;
      state      <= IDLE;
      cnt        <= '0;
      digits_out <= '0;
      valid_out  <= '0;
      upd_pulse  <= 1'b0;
      err_pulse  <= 1'b0;
      upd_idx    <= 3'd0;
    end else begin
      s_seg     <= in_seg;
      s_sel     <= in_sel;
      p_seg     <= s_seg;
      p_sel     <= s_sel;
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      upd_pulse <= commit && dec_hit;
      err_pulse <= commit && !dec_hit;
      if (commit) begin
        upd_idx <= sel_idx;
        for (int k = 0; k < DIGITS; k++) begin
          if (s_sel[k]) begin
            valid_out[k] <= dec_hit;
            if (dec_hit) digits_out[4*k +: 4] <= dec_nib;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed plan steps plus random scan traffic against a run-length model.
// Model: a digit commits once a one-hot sample has been seen STABLE_CYCLES times in a row.
module tb_seg7_scan_capture;

  localparam int DIGITS = 4;
  localparam int SC     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  sel;
  logic [6:0]  seg_pin;
  logic [3:0]  sel_pin;
  logic [15:0] digits_out;
  logic [3:0]  valid_out;
  logic        upd_pulse, err_pulse;
  logic [2:0]  upd_idx;

  always #5 clk = ~clk;

`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
  assign seg_pin = ~seg;
  assign sel_pin = ~sel;
`else
  assign seg_pin = seg;
  assign sel_pin = sel;
`endif

  seg7_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(SC), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_pin),
    .dig_sel    (sel_pin),
    .digits_out (digits_out),
    .valid_out  (valid_out),
    .upd_pulse  (upd_pulse),
    .err_pulse  (err_pulse),
    .upd_idx    (upd_idx)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [15:0] e_dig;
  logic [3:0]  e_val;
  logic        e_upd, e_err;
  logic [2:0]  e_idx;
  logic [10:0] last;
  int          run;
  logic        pend;
  logic [10:0] pend_smp;

  function automatic int lookup(input logic [6:0] p);
    int r = -1;
    for (int i = 0; i < 16; i++) if (tbl[i] == p) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    int k, v;
    @(posedge clk);
    if (!rst_n) begin
      e_dig = '0; e_val = '0; e_upd = 1'b0; e_err = 1'b0; e_idx = '0;
      last = '0; run = 1; pend = 1'b0; pend_smp = '0;
    end else begin
      e_upd = 1'b0;
      e_err = 1'b0;
      if (pend) begin
        k = 0;
        for (int i = 0; i < DIGITS; i++) if (pend_smp[i]) k = i;
        v = lookup(pend_smp[10:4]);
        e_idx = 3'(k);
        if (v >= 0) begin
          e_dig[4*k +: 4] = 4'(v);
          e_val[k] = 1'b1;
          e_upd = 1'b1;
        end else begin
          e_val[k] = 1'b0;
          e_err = 1'b1;
        end
      end
      if ({seg, sel} == last) run++;
      else begin
        run  = 1;
        last = {seg, sel};
      end
      pend     = (run == SC) && $onehot(sel);
      pend_smp = {seg, sel};
    end
    #1;
    chk("digits_out", 32'(digits_out), 32'(e_dig));
    chk("valid_out",  32'(valid_out),  32'(e_val));
    chk("upd_pulse",  32'(upd_pulse),  32'(e_upd));
    chk("err_pulse",  32'(err_pulse),  32'(e_err));
    chk("upd_idx",    32'(upd_idx),    32'(e_idx));
    chk("pulse_excl", 32'(upd_pulse & err_pulse), 32'd0);
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    sel = d;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    seg   = '0;
    sel   = '0;
    cyc();
    cyc();
    chk("reset_digits", 32'(digits_out), 32'd0);
    chk("reset_valid",  32'(valid_out),  32'd0);
    rst_n = 1'b1;

    // Digit 0 shows '0' for 12 cycles
    hold(7'b0111111, 4'b0001, 12);
    chk("t1_valid",  32'(valid_out),  32'h1);
    chk("t1_digits", 32'(digits_out), 32'h0);

    // '5' on digit 2 then 'F' on digit 3
    do_reset();
    hold(7'b1101101, 4'b0100, 10);
    hold(7'b1110001, 4'b1000, 10);
    chk("t2_digits", 32'(digits_out), 32'hF500);
    chk("t2_valid",  32'(valid_out),  32'hC);

    // Alternating patterns never settle long enough
    for (int i = 0; i < 8; i++) hold((i % 2 == 0) ? 7'b1111111 : 7'b1111101, 4'b0010, 5);
    chk("t3_valid1",  32'(valid_out[1]),     32'd0);
    chk("t3_digit1",  32'(digits_out[7:4]),  32'd0);

    // Commit '7' on digit 0 then an unknown pattern
    do_reset();
    hold(7'b0000111, 4'b0001, 10);
    hold(7'b1000000, 4'b0001, 10);
    chk("t4_valid0", 32'(valid_out[0]),    32'd0);
    chk("t4_digit0", 32'(digits_out[3:0]), 32'h7);

    // Invalid selects never commit
    hold(7'b0000110, 4'b0011, 20);
    hold(7'b0000110, 4'b0000, 20);
    chk("t5_digit0", 32'(digits_out[3:0]), 32'h7);

    // Reset in the middle of a count, then recommit with the input still held
    do_reset();
    hold(7'b1001111, 4'b0001, 5);
    do_reset();
    chk("t6_reset_digits", 32'(digits_out), 32'd0);
    repeat (8) cyc();
    chk("t6_no_early", 32'(upd_pulse), 32'd0);
    cyc();
    chk("t6_upd",    32'(upd_pulse),       32'd1);
    chk("t6_digit0", 32'(digits_out[3:0]), 32'h3);
    hold(7'b1001111, 4'b0001, 4);

    // Random scan traffic
    for (int n = 0; n < 200; n++) begin
      logic [6:0] s;
      logic [3:0] d;
      if ($urandom_range(0, 99) < 3) do_reset();
      d = ($urandom_range(0, 99) < 80) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      s = ($urandom_range(0, 99) < 70) ? tbl[$urandom_range(0, 15)] : 7'($urandom);
      hold(s, d, $urandom_range(1, 14));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
